// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM state codes
// and the sign_mode encodings.
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle between a requester and the sequential multiplier.
interface mult_seq_if #(parameter int WIDTH = 32);

  logic                 start;
  logic                 sign_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cancel;
  logic                 cpu_stall;
  logic [2*WIDTH-1:0]   z;
  logic                 busy;
  logic                 finish;

  modport master (
    output start, sign_mode, a, b, cancel, cpu_stall,
    input  z, busy, finish
  );

  modport slave (
    input  start, sign_mode, a, b, cancel, cpu_stall,
    output z, busy, finish
  );

endinterface

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negation: yields the magnitude of a signed
// operand, or re-applies the sign to an unsigned product.
module mult_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_seq.sv
// Iterative WIDTH-cycle shift-add multiplier with signed/unsigned modes,
// pipeline stall, cancel and restart-on-start.
import mult_pkg::*;

module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  mult_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t              state;
  logic [WIDTH-1:0]    mult_a;
  logic [WIDTH-1:0]    mult_b;
  logic [WIDTH-1:0]    partial;
  logic [CW-1:0]       count;
  logic                negate;
  logic [2*WIDTH-1:0]  z_reg;

  logic                signed_mode;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  product_next;
  logic [2*WIDTH-1:0]  product_fixed;

  assign signed_mode = (bus.sign_mode == MODE_SIGNED);

  mult_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
    .value  (bus.a),
    .negate (signed_mode & bus.a[WIDTH-1]),
    .result (a_mag)
  );

  mult_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
    .value  (bus.b),
    .negate (signed_mode & bus.b[WIDTH-1]),
    .result (b_mag)
  );

  // One shift-add step; the last step's shifted pair is the full magnitude product.
  assign sum          = {1'b0, partial} + (mult_b[0] ? {1'b0, mult_a} : {(WIDTH+1){1'b0}});
  assign product_next = {sum, mult_b[WIDTH-1:1]};

  mult_sign_fix #(.WIDTH(2*WIDTH)) u_fix_z (
    .value  (product_next),
    .negate (negate),
    .result (product_fixed)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mult_a  <= '0;
      mult_b  <= '0;
      partial <= '0;
      count   <= '0;
      negate  <= 1'b0;
      z_reg   <= '0;
    end else if (bus.start) begin
      state   <= RUN;
      mult_a  <= a_mag;
      mult_b  <= b_mag;
      partial <= '0;
      count   <= CW'(WIDTH);
      negate  <= signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end else begin
      case (state)
        RUN: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else if (!bus.cpu_stall) begin
            partial <= sum[WIDTH:1];
            mult_b  <= {sum[0], mult_b[WIDTH-1:1]};
            count   <= count - CW'(1);
            if (count == CW'(1)) begin
              z_reg <= product_fixed;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.finish = (state == DONE);
  assign bus.z      = z_reg;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner operands, stall, cancel,
// restart and mid-operation reset, then randomized operands against a model.
module tb_mult_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference product computed with plain integer arithmetic.
  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
    longint      sx;
    longint      sy;
    logic [63:0] ux;
    logic [63:0] uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one start at a negedge and count edges until finish, bounded.
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic mode,
                               input int stall_start, input int stall_len, output int cycles);
    bus.a         = ia;
    bus.b         = ib;
    bus.sign_mode = mode;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles    = 1;
    while (!bus.finish && cycles < 200) begin
      bus.cpu_stall = (cycles >= stall_start) && (cycles < stall_start + stall_len);
      @(negedge clk);
      cycles++;
    end
    bus.cpu_stall = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic mode, input logic [63:0] exp_z,
                       input int stall_start, input int stall_len);
    int cyc;
    applyStimulus(ia, ib, mode, stall_start, stall_len, cyc);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(33 + stall_len));
    checkOutput({tag, "_finish"}, {63'd0, bus.finish}, 64'd1);
    checkOutput({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    checkOutput({tag, "_z"}, bus.z, exp_z);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {63'd0, bus.finish}, 64'd0);
    checkOutput({tag, "_hold"}, bus.z, exp_z);
  endtask

  initial begin
    int          pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rm;
    int          ss;
    int          sl;

    bus.start     = 1'b0;
    bus.sign_mode = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cancel    = 1'b0;
    bus.cpu_stall = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_z", bus.z, 64'd0);
    checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset_finish", {63'd0, bus.finish}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    runOp("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 0);
    runOp("sneg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
    runOp("sneg1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0, 0);
    runOp("sminsq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 0);
    runOp("uminsq", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0, 0);
    runOp("umin2", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 0, 0);
    runOp("stall7x9", 32'd7, 32'd9, 1'b0, 64'd63, 10, 5);

    // Cancel mid-run must leave the previous result in place.
    runOp("p12x12", 32'd12, 32'd12, 1'b0, 64'd144, 0, 0);
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checkOutput("cancel_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("cancel_finish", {63'd0, bus.finish}, 64'd0);
    checkOutput("cancel_z", bus.z, 64'd144);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.finish) pulses++;
    end
    checkOutput("cancel_nopulse", 64'(pulses), 64'd0);
    checkOutput("cancel_zhold", bus.z, 64'd144);

    // Restart while an operation is in flight.
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    runOp("restart", 32'd11, 32'd13, 1'b0, 64'd143, 0, 0);

    // Reset in the middle of an operation.
    bus.a         = 32'h1234_5678;
    bus.b         = 32'h9ABC_DEF0;
    bus.sign_mode = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_z", bus.z, 64'd0);
    checkOutput("midreset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("midreset_finish", {63'd0, bus.finish}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.finish) pulses++;
    end
    checkOutput("midreset_nopulse", 64'(pulses), 64'd0);

    for (int i = 0; i < 24; i++) begin
      ra = pickOperand();
      rb = pickOperand();
      rm = 1'($urandom_range(0, 1));
      ss = $urandom_range(2, 20);
      sl = $urandom_range(0, 4);
      runOp($sformatf("rnd%0d", i), ra, rb, rm, refProduct(ra, rb, rm), ss, sl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
